sram_sync_controller: RTL and testbench

Single-port synchronous SRAM controller with a word-addressed on-chip storage array, per-byte write enables and a fixed, pipelined read latency. It sits between a simple request bus (req/we/addr/wdata/be) and local memory, accepting one operation per clock with no back-pressure. Read data returns on rdata qualified by a one-cycle rvalid strobe.

---
 rtl/sram_sync_controller_if.sv | 25 ++
 rtl/sram_sync_controller.sv | 74 +++++++
 tb/tb_sram_sync_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sram_sync_controller_if.sv
// Request/response bus for sram_sync_controller: req/we/addr/wdata/be in, rdata/rvalid out.
interface sram_sync_controller_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, rvalid
  );
endinterface

// File: rtl/sram_sync_controller.sv
// Single-port synchronous SRAM controller with fixed pipelined read latency RD_LAT.
// Define SRAM_SYNC_CTRL_BE_EN to honour per-byte write enables; otherwise writes are full-word.
module sram_sync_controller #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input logic                    clk,
  input logic                    rst,
  sram_sync_controller_if.slave  bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8, at least 8");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("RD_LAT must be in 1..4");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [BE_W-1:0]   be_eff;
  logic              wr_en;
  logic              rd_en;
  logic [RD_LAT-1:0] pipe_v;
  logic [DATA_W-1:0] pipe_d [RD_LAT];

`ifdef SRAM_SYNC_CTRL_BE_EN
  assign be_eff = bus.be;
`else
  // be is deliberately folded away: every write covers the whole word.
  assign be_eff = bus.be | {BE_W{1'b1}};
`endif

  assign wr_en = bus.req & bus.we;
  assign rd_en = bus.req & ~bus.we;

  // Storage has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be_eff[i]) begin
          mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  // Data stages only advance behind a valid bit, so the last stage holds the
  // most recent returned word while rvalid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_en;
      if (rd_en) begin
        pipe_d[0] <= mem[bus.addr];
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  assign bus.rdata  = pipe_d[RD_LAT-1];
  assign bus.rvalid = pipe_v[RD_LAT-1];
endmodule

// File: tb/tb_sram_sync_controller.sv
// Self-checking bench for sram_sync_controller: directed steps plus random traffic vs a cycle-scheduled reference model.
module tb_sram_sync_controller;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_sync_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sram_sync_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: a word array, and expected read results keyed by the edge at
  // which rvalid must be seen high.
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] due [int];
  logic [DATA_W-1:0] hold_m = '0;
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rq, input logic w,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [BE_W-1:0] b);
    logic [BE_W-1:0] mask;
    rst       = r;
    bus.req   = rq;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.be    = b;
`ifdef SRAM_SYNC_CTRL_BE_EN
    mask = b;
`else
    mask = '1;
`endif
    @(posedge clk);
    cyc++;
    if (r) begin
      due.delete();
      hold_m = '0;
    end else if (rq && w) begin
      for (int i = 0; i < int'(BE_W); i++)
        if (mask[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
    end else if (rq) begin
      due[cyc + int'(RD_LAT) - 1] = mem_m[a];
    end
    #1;
    if (due.exists(cyc)) begin
      hold_m = due[cyc];
      due.delete(cyc);
      check("rvalid_pulse", {31'b0, bus.rvalid}, 32'd1);
      check("rdata", bus.rdata, hold_m);
    end else begin
      check("rvalid_idle", {31'b0, bus.rvalid}, 32'd0);
      check("rdata_hold", bus.rdata, hold_m);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
    step(1'b0, 1'b1, 1'b1, a, d, b);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    step(1'b0, 1'b1, 1'b0, a, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;

    // Reset held with read requests pending: no strobe during or after.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, ADDR_W'(i), '0, '0);
    idle(RD_LAT + 2);

    // Preload every word so all later reads have a defined reference.
    for (int i = 0; i < int'(DEPTH); i++) wr(ADDR_W'(i), $urandom, '1);
    idle(2);

    // Full-word write then read.
    wr(10'h005, 32'hDEAD_BEEF, 4'hF);
    rd(10'h005);
    idle(RD_LAT + 1);

    // Byte enables (expected value depends on the build option via the model).
    wr(10'h010, 32'h1122_3344, 4'hF);
    wr(10'h010, 32'hAABB_CCDD, 4'b0101);
    rd(10'h010);
    idle(RD_LAT);
    wr(10'h010, 32'h5566_7788, 4'b0000);
    rd(10'h010);
    idle(RD_LAT);

    // Address extremes, no aliasing.
    wr(10'h000, 32'h0000_0001, 4'hF);
    wr(10'h3FF, 32'hFFFF_FFFF, 4'hF);
    rd(10'h000);
    rd(10'h3FF);
    idle(RD_LAT + 1);

    // Back-to-back reads, then write-after-read to the first address.
    for (int i = 0; i < 4; i++) wr(ADDR_W'(10'h020 + i), DATA_W'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) rd(ADDR_W'(10'h020 + i));
    wr(10'h020, 32'h0000_0099, 4'hF);
    idle(RD_LAT + 1);
    rd(10'h020);
    idle(RD_LAT);

    // Reset on the edge after a read: read is dropped, storage preserved.
    rd(10'h005);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    idle(RD_LAT + 1);
    rd(10'h005);
    idle(RD_LAT);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 50) == 0, ($urandom % 4) != 0, $urandom % 2,
           ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom, BE_W'($urandom));
    end
    idle(RD_LAT + 2);

    check("drained", DATA_W'(due.num()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
